// File: rtl/keypad_debounce_filter.sv
// Keypad front end: synchronises N raw key lines, accepts a lone key after DELAY
// stable cycles, and reports code, press/repeat strobe, held level and multi-key errors.
module keypad_debounce_filter #(
    parameter int N_KEYS = 12,
    parameter int DELAY  = 4,
    parameter int REPEAT = 0,
    parameter int CNT_W  = 8,
    parameter int CODE_W = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [N_KEYS-1:0] key_in,
    output logic [CODE_W-1:0] key_code,
    output logic              key_strobe,
    output logic              key_valid,
    output logic              multi_err
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT);

    state_t              state_q;
    logic [N_KEYS-1:0]   sync1_q;
    logic [N_KEYS-1:0]   sync_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    rep_q;
    logic [CODE_W-1:0]   key_code_q;
    logic                key_strobe_q;
    logic                key_valid_q;
    logic                multi_err_q;

    logic                zero;
    logic                onehot;
    logic                multi;
    logic [CODE_W-1:0]   idx;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    rep_inc;

    // Clearing the lowest set bit leaves zero only when at most one bit was set.
    assign zero   = (sync_q == '0);
    assign onehot = !zero && ((sync_q & (sync_q - N_KEYS'(1))) == '0);
    assign multi  = !zero && !onehot;

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (sync_q[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign rep_inc = (rep_q == '1) ? rep_q : rep_q + CNT_W'(1);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q      <= IDLE;
            sync1_q      <= '0;
            sync_q       <= '0;
            cnt_q        <= '0;
            rep_q        <= '0;
            key_code_q   <= '0;
            key_strobe_q <= 1'b0;
            key_valid_q  <= 1'b0;
            multi_err_q  <= 1'b0;
        end else begin
            sync1_q      <= key_in;
            sync_q       <= sync1_q;
            key_strobe_q <= 1'b0;
            multi_err_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (onehot) begin
                        key_code_q <= idx;
                        cnt_q      <= CNT_W'(1);
                        if (DELAY == 1) begin
                            state_q      <= HELD;
                            key_strobe_q <= 1'b1;
                            key_valid_q  <= 1'b1;
                            rep_q        <= '0;
                        end else begin
                            state_q <= DEBOUNCE;
                        end
                    end else if (multi) begin
                        state_q     <= RELEASE;
                        cnt_q       <= '0;
                        multi_err_q <= 1'b1;
                    end
                end

                DEBOUNCE: begin
                    if (multi) begin
                        state_q     <= RELEASE;
                        cnt_q       <= '0;
                        multi_err_q <= 1'b1;
                    end else if (zero) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (idx != key_code_q) begin
                        key_code_q <= idx;
                        cnt_q      <= CNT_W'(1);
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == DELAY_C) begin
                            state_q      <= HELD;
                            key_strobe_q <= 1'b1;
                            key_valid_q  <= 1'b1;
                            rep_q        <= '0;
                        end
                    end
                end

                HELD: begin
                    if (onehot && (idx == key_code_q)) begin
                        if (REPEAT > 0) begin
                            if (rep_inc == REPEAT_C) begin
                                key_strobe_q <= 1'b1;
                                rep_q        <= '0;
                            end else begin
                                rep_q <= rep_inc;
                            end
                        end
                    end else begin
                        // The releasing zero sample is itself the first quiet cycle.
                        state_q     <= (zero && DELAY == 1) ? IDLE : RELEASE;
                        key_valid_q <= 1'b0;
                        multi_err_q <= multi;
                        cnt_q       <= zero ? CNT_W'(1) : '0;
                    end
                end

                RELEASE: begin
                    if (zero) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == DELAY_C) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign key_code   = key_code_q;
    assign key_strobe = key_strobe_q;
    assign key_valid  = key_valid_q;
    assign multi_err  = multi_err_q;

endmodule

// File: tb/tb_keypad_debounce_filter.sv
// Directed bench for keypad_debounce_filter: one instance without auto-repeat,
// one with REPEAT=10, sharing clock, clear and key lines.
module tb_keypad_debounce_filter;

    localparam int NK = 12;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clear = 1'b0;
    logic [NK-1:0] key_in = '0;

    logic [CW-1:0] code0, code1;
    logic          stb0, stb1, val0, val1, err0, err1;

    int vectors = 0;
    int miscompares = 0;
    int stb_cnt = 0;
    int val_cnt = 0;
    int err_cnt = 0;
    int rep_stb_cnt = 0;

    keypad_debounce_filter #(.N_KEYS(NK), .DELAY(4), .REPEAT(0), .CNT_W(8), .CODE_W(CW)) dut0 (
        .clk(clk), .clear(clear), .key_in(key_in),
        .key_code(code0), .key_strobe(stb0), .key_valid(val0), .multi_err(err0)
    );

    keypad_debounce_filter #(.N_KEYS(NK), .DELAY(4), .REPEAT(10), .CNT_W(8), .CODE_W(CW)) dut1 (
        .clk(clk), .clear(clear), .key_in(key_in),
        .key_code(code1), .key_strobe(stb1), .key_valid(val1), .multi_err(err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later; tallies dut0 pulses/levels.
    task automatic tick();
        @(posedge clk);
        #1;
        if (stb0) stb_cnt++;
        if (val0) val_cnt++;
        if (err0) err_cnt++;
        if (stb1) rep_stb_cnt++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        stb_cnt = 0;
        val_cnt = 0;
        err_cnt = 0;
        rep_stb_cnt = 0;
    endtask

    initial begin
        // Reset state
        ticks(2);
        chk("reset_code", code0, 0);
        chk("reset_strobe", stb0, 0);
        chk("reset_valid", val0, 0);
        chk("reset_err", err0, 0);
        clear = 1'b1;
        ticks(3);

        // Clean press of key 5 (k = next edge)
        key_in = 12'd1 << 5;
        ticks(2);                               // k+1
        chk("t1_code_presync", code0, 0);
        tick();                                 // k+2
        chk("t1_code_debounce", code0, 5);
        ticks(2);                               // k+4
        chk("t1_no_early_strobe", stb0, 0);
        chk("t1_no_early_valid", val0, 0);
        tick();                                 // k+5
        chk("t1_strobe", stb0, 1);
        chk("t1_valid", val0, 1);
        chk("t1_code", code0, 5);
        clear_counts();
        ticks(14);                              // k+19
        chk("t1_single_strobe", stb_cnt, 0);
        chk("t1_valid_held", val_cnt, 14);
        key_in = '0;                            // zero before j = k+20
        ticks(2);                               // j+1
        chk("t1_valid_hold_j1", val0, 1);
        tick();                                 // j+2
        chk("t1_valid_drop_j2", val0, 0);
        tick();                                 // j+3
        key_in = 12'd1 << 5;                    // raw before j+4, seen at j+6 in IDLE
        ticks(5);
        chk("t1_repress_no_early", stb0, 0);
        tick();
        chk("t1_repress_at_idle_edge", stb0, 1);
        key_in = '0;
        ticks(10);

        // Press bounce on key 3
        clear_counts();
        key_in = 12'd1 << 3;
        tick();                                 // k
        tick();                                 // k+1
        key_in = '0;
        tick();                                 // k+2
        chk("t2_code_candidate", code0, 3);
        key_in = 12'd1 << 3;
        tick();
        tick();                                 // k+4
        key_in = '0;
        ticks(10);
        chk("t2_no_strobe", stb_cnt, 0);
        chk("t2_no_valid", val_cnt, 0);
        key_in = 12'd1 << 4;
        ticks(5);
        chk("t2_idle_no_early", stb0, 0);
        tick();
        chk("t2_idle_press_strobe", stb0, 1);
        chk("t2_idle_press_code", code0, 4);
        key_in = '0;
        ticks(10);

        // Multi-key: 1 and 7 together
        clear_counts();
        key_in = (12'd1 << 1) | (12'd1 << 7);
        ticks(2);                               // k+1
        chk("t3_err_not_yet", err0, 0);
        tick();                                 // k+2
        chk("t3_err_pulse", err0, 1);
        chk("t3_code_kept", code0, 4);
        tick();                                 // k+3
        chk("t3_err_one_cycle", err0, 0);
        ticks(2);                               // k+5
        key_in = '0;
        ticks(5);                               // k+10
        key_in = 12'd1 << 7;                    // k' = k+11
        ticks(5);
        chk("t3_k7_no_early", stb0, 0);
        tick();
        chk("t3_k7_strobe", stb0, 1);
        chk("t3_k7_code", code0, 7);
        chk("t3_err_count", err_cnt, 1);
        chk("t3_strobe_count", stb_cnt, 1);
        key_in = '0;
        ticks(10);

        // Auto-repeat on key 9 (dut1), held 40 cycles
        clear_counts();
        key_in = 12'd1 << 9;
        for (int e = 0; e <= 45; e++) begin
            if (e == 40) key_in = '0;
            tick();
            chk($sformatf("t4_rep_strobe_e%0d", e), stb1,
                (e == 5 || e == 15 || e == 25 || e == 35) ? 1 : 0);
            chk($sformatf("t4_rep_valid_e%0d", e), val1, (e >= 5 && e <= 41) ? 1 : 0);
        end
        chk("t4_rep_strobe_total", rep_stb_cnt, 4);
        chk("t4_norep_strobe_total", stb_cnt, 1);
        ticks(8);

        // Release bounce after accepting key 2
        key_in = 12'd1 << 2;
        ticks(5);
        tick();                                 // k+5
        chk("t5_strobe", stb0, 1);
        chk("t5_code", code0, 2);
        ticks(3);
        clear_counts();
        key_in = '0;                            // before j
        tick();                                 // j
        key_in = 12'd1 << 2;
        tick();                                 // j+1
        chk("t5_valid_before_drop", val0, 1);
        key_in = '0;
        tick();                                 // j+2
        chk("t5_valid_first_low", val0, 0);
        key_in = 12'd1 << 2;
        tick();                                 // j+3
        key_in = '0;
        ticks(3);                               // j+6
        key_in = 12'd1 << 6;                    // before j+7: still in RELEASE
        ticks(10);
        chk("t5_no_second_strobe", stb_cnt, 0);
        chk("t5_valid_stays_low", val0, 0);
        chk("t5_code_holds", code0, 2);
        key_in = '0;
        ticks(12);

        // Async clear during DEBOUNCE and HELD
        key_in = 12'd1 << 8;
        ticks(4);                               // k+3, cnt = 2
        chk("t6_code_before_clear", code0, 8);
        #1 clear = 1'b0;
        #1;
        chk("t6_clear_code", code0, 0);
        chk("t6_clear_strobe", stb0, 0);
        chk("t6_clear_valid", val0, 0);
        #3 clear = 1'b1;
        tick();                                 // k+4: first sync edge again
        tick();                                 // k+5
        chk("t6_no_original_strobe", stb0, 0);
        ticks(3);                               // k+8
        chk("t6_no_early_strobe", stb0, 0);
        tick();                                 // k+9
        chk("t6_strobe_after_clear", stb0, 1);
        chk("t6_valid_after_clear", val0, 1);
        ticks(2);
        #1 clear = 1'b0;
        #1;
        chk("t6_held_clear_valid", val0, 0);
        chk("t6_held_clear_code", code0, 0);
        #3 clear = 1'b1;
        ticks(5);
        chk("t6_held_no_early", stb0, 0);
        chk("t6_held_valid_low", val0, 0);
        tick();
        chk("t6_held_restrobe", stb0, 1);
        chk("t6_held_revalid", val0, 1);
        key_in = '0;
        ticks(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
